// File: rtl/oam_dma_if.sv
// Bus-side signal bundle of the sprite DMA engine: the muxed memory/PPU
// strobes driven by the engine and the routed read data returned to it.
// The engine uses the master modport; the memory/PPU side uses slave.
interface oam_dma_if;
    logic [15:0] bus_address;
    logic        bus_rd;
    logic [15:0] bus_ea;
    logic [7:0]  bus_dout;
    logic        bus_wreq;
    logic [7:0]  bus_din;

    modport master (
        output bus_address,
        output bus_rd,
        output bus_ea,
        output bus_dout,
        output bus_wreq,
        input  bus_din
    );

    modport slave (
        input  bus_address,
        input  bus_rd,
        input  bus_ea,
        input  bus_dout,
        input  bus_wreq,
        output bus_din
    );
endinterface

// File: rtl/oam_dma.sv
// Sprite DMA engine sitting between the CPU bus and memory/PPU.
// A CPU write to DMA_REG_ADDR halts the CPU and copies the 256 bytes of page
// {data,8'h00} to OAM_DATA_ADDR, one read and one write cpu cycle per byte.
// While idle the CPU bus strobes pass straight through to the bus.
//
// Build option: define OAM_DMA_ODD_ALIGN_EN to insert one extra dummy cycle
// when the transfer starts on an odd cpu cycle (2A03 behaviour: 514 cycles
// instead of 513). Without it the transfer always takes 513 cycles.
module oam_dma #(
    parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_ce,
    input  logic [15:0] cpu_address,
    input  logic        cpu_rd,
    input  logic [15:0] cpu_ea,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_wreq,
    output logic        cpu_halt,
    output logic        busy,
    oam_dma_if.master   bus
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ALIGN = 3'd1;
    localparam logic [2:0] ST_ODD   = 3'd2;
    localparam logic [2:0] ST_READ  = 3'd3;
    localparam logic [2:0] ST_WRITE = 3'd4;

    logic [2:0] state_reg;
    logic [2:0] state_next;
    logic [7:0] page_reg;
    logic [7:0] page_next;
    logic [7:0] idx_reg;
    logic [7:0] idx_next;
    logic [7:0] latch_reg;
    logic [7:0] latch_next;
    logic       par_reg;

    logic       trigger;
    logic       last_byte;

    // Only an idle engine listens for the trigger write; once running, every
    // CPU input (including further trigger writes) is ignored.
    assign trigger   = (state_reg == ST_IDLE) && cpu_ce && cpu_wreq &&
                       (cpu_ea == DMA_REG_ADDR);
    assign last_byte = (idx_reg == 8'hFF);

    // Next-state and datapath register updates, advancing only on cpu_ce
    always_comb begin
        state_next = state_reg;
        page_next  = page_reg;
        idx_next   = idx_reg;
        latch_next = latch_reg;
        case (state_reg)
            ST_IDLE: begin
                if (trigger) begin
                    page_next  = cpu_dout;
                    idx_next   = 8'h00;
                    state_next = ST_ALIGN;
                end
            end
            ST_ALIGN: begin
                if (cpu_ce) begin
`ifdef OAM_DMA_ODD_ALIGN_EN
                    // Started on an odd cycle: burn one more dummy cycle.
                    state_next = par_reg ? ST_ODD : ST_READ;
`else
                    state_next = ST_READ;
`endif
                end
            end
            ST_ODD: begin
                if (cpu_ce) begin
                    state_next = ST_READ;
                end
            end
            ST_READ: begin
                if (cpu_ce) begin
                    latch_next = bus.bus_din;
                    state_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (cpu_ce) begin
                    // idx wraps within the page; the page never increments.
                    idx_next   = idx_reg + 8'd1;
                    state_next = last_byte ? ST_IDLE : ST_READ;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Engine state and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            page_reg  <= 8'h00;
            idx_reg   <= 8'h00;
            latch_reg <= 8'h00;
        end else begin
            state_reg <= state_next;
            page_reg  <= page_next;
            idx_reg   <= idx_next;
            latch_reg <= latch_next;
        end
    end

    // CPU cycle parity, toggling on every cpu_ce whether or not DMA runs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_reg <= 1'b0;
        end else if (cpu_ce) begin
            par_reg <= ~par_reg;
        end
    end

    // Halt and busy decode straight from the state register, so they rise
    // the clock after the trigger and drop at once on reset.
    assign busy     = (state_reg != ST_IDLE);
    assign cpu_halt = busy;

    // Bus mux: CPU pass-through when idle, engine-owned strobes otherwise
    always_comb begin
        bus.bus_address = cpu_address;
        bus.bus_rd      = cpu_rd;
        bus.bus_ea      = cpu_ea;
        bus.bus_dout    = cpu_dout;
        bus.bus_wreq    = cpu_wreq;
        case (state_reg)
            ST_IDLE: begin
                bus.bus_address = cpu_address;
                bus.bus_rd      = cpu_rd;
                bus.bus_ea      = cpu_ea;
                bus.bus_dout    = cpu_dout;
                bus.bus_wreq    = cpu_wreq;
            end
            ST_READ: begin
                bus.bus_address = {page_reg, idx_reg};
                bus.bus_rd      = 1'b1;
                bus.bus_ea      = OAM_DATA_ADDR;
                bus.bus_dout    = latch_reg;
                bus.bus_wreq    = 1'b0;
            end
            ST_WRITE: begin
                // Write strobe lasts exactly the cpu_ce clock, so the OAM
                // address auto-increments once per byte.
                bus.bus_address = {page_reg, idx_reg};
                bus.bus_rd      = 1'b0;
                bus.bus_ea      = OAM_DATA_ADDR;
                bus.bus_dout    = latch_reg;
                bus.bus_wreq    = cpu_ce;
            end
            default: begin
                // Dummy alignment cycles: nothing is strobed.
                bus.bus_address = {page_reg, idx_reg};
                bus.bus_rd      = 1'b0;
                bus.bus_ea      = OAM_DATA_ADDR;
                bus.bus_dout    = latch_reg;
                bus.bus_wreq    = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_oam_dma.sv
// Self-checking bench for oam_dma: randomized CPU traffic, a transaction-level
// reference model (DMA length from cycle parity, byte n read in the n-th
// read/write pair) compared against the DUT every clock, plus literal checks.
module tb_oam_dma;

`ifdef OAM_DMA_ODD_ALIGN_EN
    localparam bit ODD_EN  = 1'b1;
    localparam int ODD_LEN = 514;
`else
    localparam bit ODD_EN  = 1'b0;
    localparam int ODD_LEN = 513;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cpu_ce = 1'b0;
    logic [15:0] cpu_address = 16'h0000;
    logic        cpu_rd = 1'b0;
    logic [15:0] cpu_ea = 16'h0000;
    logic [7:0]  cpu_dout = 8'h00;
    logic        cpu_wreq = 1'b0;
    logic        cpu_halt;
    logic        busy;

    oam_dma_if bus();

    oam_dma dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cpu_ce      (cpu_ce),
        .cpu_address (cpu_address),
        .cpu_rd      (cpu_rd),
        .cpu_ea      (cpu_ea),
        .cpu_dout    (cpu_dout),
        .cpu_wreq    (cpu_wreq),
        .cpu_halt    (cpu_halt),
        .busy        (busy),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    // Memory model: registered read, data valid one clock after the address
    logic [7:0] mem [0:65535];
    always @(posedge clk) bus.bus_din <= mem[bus.bus_address];

    int checks = 0;
    int passes = 0;

    task automatic chk_m(input string name, input logic [63:0] act,
                         input logic [63:0] exp, input logic [63:0] msk);
        checks++;
        if ((((act ^ exp) & msk) == 64'd0) && !$isunknown(act & msk))
            passes++;
        else
            $display("FAIL %s actual=%h required=%h t=%0t", name, act & msk, exp & msk, $time);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_m(name, act, exp, '1);
    endtask

    // ---------------- reference model ----------------
    bit         m_busy = 1'b0;
    logic [7:0] m_page = 8'h00;
    int         m_k = 0;        // busy cpu_ce periods already elapsed
    int         m_align = 1;    // dummy cycles before the first read
    int         ce_total = 0;   // cpu_ce count since reset (parity source)

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy   = 1'b0;
            ce_total = 0;
        end else if (cpu_ce) begin
            if (!m_busy) begin
                if (cpu_wreq && cpu_ea == 16'h4014) begin
                    m_busy  = 1'b1;
                    m_page  = cpu_dout;
                    m_k     = 0;
                    m_align = (ODD_EN && ((ce_total + 1) % 2 == 1)) ? 2 : 1;
                end
            end else begin
                m_k++;
                if (m_k == m_align + 512) m_busy = 1'b0;
            end
            ce_total++;
        end
    end

    // Per-cycle comparison of every DUT output against the model
    bit          chk_en = 1'b0;
    logic [63:0] c_act, c_exp, c_msk;
    logic [15:0] c_addr;
    int          c_j;
    always @(negedge clk) begin
        if (chk_en) begin
            c_act = {20'd0, busy, cpu_halt, bus.bus_rd, bus.bus_wreq,
                     bus.bus_address, bus.bus_ea, bus.bus_dout};
            if (!m_busy) begin
                c_exp = {20'd0, 2'b00, cpu_rd, cpu_wreq, cpu_address, cpu_ea, cpu_dout};
                c_msk = {20'd0, 44'hFFF_FFFF_FFFF};
            end else if (m_k < m_align) begin
                c_exp = {20'd0, 4'b1100, 40'd0};
                c_msk = {20'd0, 4'hF, 40'd0};
            end else begin
                c_j    = m_k - m_align;
                c_addr = {m_page, 8'(c_j / 2)};
                if (c_j % 2 == 0) begin
                    c_exp = {20'd0, 4'b1110, c_addr, 24'd0};
                    c_msk = {20'd0, 4'hF, 16'hFFFF, 24'd0};
                end else begin
                    c_exp = {20'd0, 3'b110, cpu_ce, 16'd0, 16'h2004, mem[c_addr]};
                    c_msk = {20'd0, 4'hF, 16'd0, 24'hFF_FFFF};
                end
            end
            chk_m("cycle", c_act, c_exp, c_msk);
        end
    end

    // Transaction monitors
    logic [7:0] ppu_q[$];
    int         busy_ces = 0;
    int         rd_cnt = 0;
    int         oop = 0;
    int         any_2004 = 0;
    int         wide = 0;
    bit         prev_w = 1'b0;
    logic [7:0] cur_page = 8'h00;
    always @(negedge clk) begin
        if (cpu_ce && busy) busy_ces++;
        if (busy && bus.bus_wreq && bus.bus_ea == 16'h2004) ppu_q.push_back(bus.bus_dout);
        if (busy && bus.bus_rd && cpu_ce) begin
            rd_cnt++;
            if (bus.bus_address[15:8] != cur_page) oop++;
        end
        if (bus.bus_wreq && bus.bus_ea == 16'h2004) any_2004++;
        if (prev_w && busy && bus.bus_wreq && bus.bus_ea == 16'h2004) wide++;
        prev_w = busy && bus.bus_wreq && (bus.bus_ea == 16'h2004);
    end

    // ---------------- stimulus ----------------
    task automatic rand_idle();
        cpu_wreq    = 1'($urandom);
        cpu_rd      = 1'($urandom);
        cpu_address = 16'($urandom);
        cpu_ea      = 16'($urandom);
        cpu_dout    = 8'($urandom);
    endtask

    // One CPU cycle: a single cpu_ce clock, then 1..3 quiet clocks
    task automatic cpu_cyc(input bit wr, input logic [15:0] ea, input logic [7:0] d);
        @(posedge clk); #2;
        cpu_ce      = 1'b1;
        cpu_wreq    = wr;
        cpu_ea      = ea;
        cpu_dout    = d;
        cpu_address = 16'($urandom);
        cpu_rd      = 1'($urandom);
        @(posedge clk); #2;
        cpu_ce = 1'b0;
        rand_idle();
        repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #2;
            rand_idle();
        end
    endtask

    task automatic idle_ce();
        cpu_cyc(1'b0, 16'($urandom), 8'($urandom));
    endtask

    // Random CPU activity during DMA, including stray trigger writes
    task automatic junk_ce();
        cpu_cyc(1'($urandom), ($urandom_range(0, 3) == 0) ? 16'h4014 : 16'($urandom),
                8'($urandom));
    endtask

    // par_sel: 0 = even start, 1 = odd start, 2 = trigger on the next ce
    task automatic run_dma(input logic [7:0] page, input int par_sel, output int len,
                           output bit odd);
        if (par_sel != 2)
            while ((ce_total % 2) != ((par_sel == 1) ? 0 : 1)) idle_ce();
        odd      = ((ce_total + 1) % 2 == 1);
        busy_ces = 0;
        rd_cnt   = 0;
        oop      = 0;
        cur_page = page;
        ppu_q.delete();
        cpu_cyc(1'b1, 16'h4014, page);
        chk("busy_rise", {63'd0, busy}, 64'd1);
        for (int n = 0; n < 700 && busy; n++) junk_ce();
        chk("dma_end", {62'd0, busy, cpu_halt}, 64'd0);
        len = busy_ces;
        $display("dma page=%02h odd=%0d len=%0d bytes=%0d", page, odd, len, ppu_q.size());
    endtask

    task automatic dma_check(input string tag, input logic [7:0] page, input int exp_len,
                             input int len);
        chk({tag, "_len"}, 64'(len), 64'(exp_len));
        chk({tag, "_bytes"}, 64'(ppu_q.size()), 64'd256);
        chk({tag, "_reads"}, 64'(rd_cnt), 64'd256);
        chk({tag, "_outside_page"}, 64'(oop), 64'd0);
        for (int i = 0; i < ppu_q.size() && i < 256; i++)
            chk({tag, "_data"}, 64'(ppu_q[i]), 64'(mem[{page, 8'(i)}]));
    endtask

    int len;
    bit odd;
    int w0;

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
        for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i);

        #1 rst_n = 1'b0;
        #1 chk_en = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_busy_halt", {62'd0, busy, cpu_halt}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #2;

        // Idle pass-through, same clock
        cpu_ce = 1'b1; cpu_wreq = 1'b1; cpu_ea = 16'h0300; cpu_dout = 8'h55;
        cpu_rd = 1'b1; cpu_address = 16'h8000;
        #1;
        chk("idle_wr", {39'd0, bus.bus_wreq, bus.bus_ea, bus.bus_dout}, {39'd0, 1'b1, 16'h0300, 8'h55});
        chk("idle_rd", {47'd0, bus.bus_rd, bus.bus_address}, {47'd0, 1'b1, 16'h8000});
        @(posedge clk); #2;
        cpu_ce = 1'b0; cpu_wreq = 1'b0;
        $display("idle write 0300=55 and read 8000 passed through");

        // Page 2, even start: data 00..FF in order
        run_dma(8'h02, 0, len, odd);
        chk("t1_len", 64'(len), 64'd513);
        chk("t1_bytes", 64'(ppu_q.size()), 64'd256);
        for (int i = 0; i < ppu_q.size() && i < 256; i++)
            chk("t1_data", 64'(ppu_q[i]), 64'(i));

        // Page 2, odd start
        run_dma(8'h02, 1, len, odd);
        chk("t2_len", 64'(len), 64'(ODD_LEN));
        for (int i = 0; i < ppu_q.size() && i < 256; i++)
            chk("t2_data", 64'(ppu_q[i]), 64'(i));

        // Page FF stays within FF00..FFFF
        run_dma(8'hFF, int'($urandom_range(0, 1)), len, odd);
        dma_check("t5", 8'hFF, (ODD_EN && odd) ? 514 : 513, len);

        // Back-to-back: trigger on the first idle cpu_ce
        run_dma(8'h03, 2, len, odd);
        dma_check("t6", 8'h03, (ODD_EN && odd) ? 514 : 513, len);

        // Random pages and parities
        for (int r = 0; r < 3; r++) begin
            logic [7:0] pg;
            pg = 8'($urandom);
            run_dma(pg, int'($urandom_range(0, 1)), len, odd);
            dma_check("rand", pg, (ODD_EN && odd) ? 514 : 513, len);
        end

        // Reset after 100 bytes
        busy_ces = 0;
        ppu_q.delete();
        cur_page = 8'h04;
        cpu_cyc(1'b1, 16'h4014, 8'h04);
        for (int n = 0; n < 400 && ppu_q.size() < 100; n++) junk_ce();
        chk("t4_bytes_before", 64'(ppu_q.size()), 64'd100);
        @(posedge clk); #4;
        cpu_ce = 1'b0; cpu_wreq = 1'b0;
        w0 = any_2004;
        rst_n = 1'b0;
        #1;
        chk("t4_reset_now", {62'd0, busy, cpu_halt}, 64'd0);
        repeat (6) @(posedge clk);
        #2;
        chk("t4_no_write", 64'(any_2004 - w0), 64'd0);
        rst_n = 1'b1;
        repeat (3) idle_ce();
        chk("t4_idle", {62'd0, busy, cpu_halt}, 64'd0);
        chk("t4_bytes_after", 64'(ppu_q.size()), 64'd100);
        $display("reset mid-dma after %0d bytes", ppu_q.size());

        chk("wreq_pulse", 64'(wide), 64'd0);
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    // Hard time bound so the run always terminates
    initial begin
        #2000000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
